regfile_sb: RTL and testbench

Parametrised, scoreboarded integer register file for the pipelined core generation.
- Two combinational read ports and one write-back port.
- Per-register busy bits track in-flight producers and raise a stall on RAW/WAW hazards.
- A sequenced bulk-clear engine zeroes the file without a reset, e.g. on context switch.
- Register 0 is hardwired to zero.

---
 rtl/regfile_sb.sv | 133 +++++++++++++
 tb/tb_regfile_sb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: scoreboarded integer register file with two combinational read ports,
// one write-back port, per-register busy bits, and a sequenced bulk-clear engine.
// Optional write-back to read-port bypass is compiled in when WB_BYPASS_EN is defined.
module regfile_sb #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   input  logic            rs1_used,
   output logic [XLEN-1:0] rs1_data,
   input  logic [AW-1:0]   rs2_addr,
   input  logic            rs2_used,
   output logic [XLEN-1:0] rs2_data,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_addr,
   output logic            stall,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            clr_req,
   output logic            clr_busy,
   output logic            clr_done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    clr_idx_q, clr_idx_d;
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q;

   logic clearing;
   logic fwd1, fwd2;
   logic rs1_hz, rs2_hz, waw;
   logic wb_we, iss_we;

   assign clearing = (state_q == ST_CLEAR);
   assign clr_busy = clearing;

`ifdef WB_BYPASS_EN
   assign fwd1 = wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0) && !clearing;
   assign fwd2 = wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0) && !clearing;
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   // Entry 0 is never written (write enables and the clear index exclude it), so it reads 0.
   assign rs1_data = fwd1 ? wb_data : regs_q[rs1_addr];
   assign rs2_data = fwd2 ? wb_data : regs_q[rs2_addr];

   assign rs1_hz = rs1_used && busy_q[rs1_addr] && !fwd1;
   assign rs2_hz = rs2_used && busy_q[rs2_addr] && !fwd2;
   assign waw    = iss_en && (iss_addr != '0) && busy_q[iss_addr]
                   && !(wb_en && (wb_addr == iss_addr));
   assign stall  = rs1_hz || rs2_hz || waw || clearing;

   assign wb_we  = !clearing && wb_en && (wb_addr != '0);
   assign iss_we = !clearing && iss_en && !stall && (iss_addr != '0);

   // NOTE: every entry has an async reset because the file must read zero right after
   // reset; this keeps the array in flops and prevents mapping it onto a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else if (clearing) begin
         regs_q[clr_idx_q] <= '0;
         busy_q[clr_idx_q] <= 1'b0;
      end else begin
         if (wb_we) begin
            regs_q[wb_addr] <= wb_data;
            busy_q[wb_addr] <= 1'b0;
         end
         // Issued after write-back so a same-address issue leaves the new producer busy.
         if (iss_we) begin
            busy_q[iss_addr] <= 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples the
   // pre-edge values; the next-state logic below is purely combinational.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         clr_idx_q <= AW'(1);
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // NOTE: all outputs of this block get a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      clr_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_idx_d = AW'(1);
            end
         end
         ST_CLEAR: begin
            if (clr_idx_q == AW'(NREGS - 1)) begin
               state_d = ST_DONE;
            end else begin
               clr_idx_d = clr_idx_q + AW'(1);
            end
         end
         ST_DONE: begin
            clr_done  = 1'b1;
            clr_idx_d = AW'(1);
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus randomized bench for regfile_sb against an array-based
// reference model of registers and busy bits (XLEN=32, NREGS=32).
module tb_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   rs1_addr, rs2_addr, iss_addr, wb_addr;
   logic            rs1_used, rs2_used, iss_en, wb_en, clr_req;
   logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
   logic            stall, clr_busy, clr_done;

   int checks   = 0;
   int failures = 0;

   logic [XLEN-1:0]  m_regs [NREGS];
   logic [NREGS-1:0] m_busy;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1_addr),
      .rs1_used (rs1_used),
      .rs1_data (rs1_data),
      .rs2_addr (rs2_addr),
      .rs2_used (rs2_used),
      .rs2_data (rs2_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .stall    (stall),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_busy = '0;
   endtask

   function automatic logic m_fwd(input logic [AW-1:0] a);
      return BYPASS && wb_en && (wb_addr == a) && (a != 0);
   endfunction

   function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (m_fwd(a)) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic m_stall();
      logic h1, h2, hw;
      h1 = rs1_used && m_busy[rs1_addr] && !m_fwd(rs1_addr);
      h2 = rs2_used && m_busy[rs2_addr] && !m_fwd(rs2_addr);
      hw = iss_en && (iss_addr != 0) && m_busy[iss_addr] && !(wb_en && wb_addr == iss_addr);
      return h1 || h2 || hw;
   endfunction

   task automatic settle();
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_rs1"}, rs1_data, m_read(rs1_addr));
      check({tag, "_rs2"}, rs2_data, m_read(rs2_addr));
      check({tag, "_stall"}, stall, m_stall());
   endtask

   // Applies the pending inputs to the model, then advances one clock edge.
   task automatic tick();
      logic st;
      st = m_stall();
      if (wb_en && wb_addr != 0) begin
         m_regs[wb_addr] = wb_data;
         m_busy[wb_addr] = 1'b0;
      end
      if (iss_en && !st && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs1_used = 0; rs2_used = 0; iss_en = 0; wb_en = 0; clr_req = 0;
   endtask

   initial begin
      int busy_cnt, done_cnt, stray;
      m_reset();
      idle_inputs();
      rs1_addr = 5; rs2_addr = 0; iss_addr = 0; wb_addr = 0; wb_data = '0;
      rst = 1'b1;
      settle();
      check("reset_rs1_x5", rs1_data, 32'd0);
      check("reset_rs2_x0", rs2_data, 32'd0);
      check("reset_stall", stall, 1'b0);
      check("reset_clr_busy", clr_busy, 1'b0);
      check("reset_clr_done", clr_done, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // RAW hazard on x7 resolved by write-back
      iss_en = 1; iss_addr = 7;
      settle(); check("iss7_stall", stall, m_stall());
      tick();
      iss_en = 0; rs1_addr = 7; rs1_used = 1;
      settle(); check("raw7_stall", stall, m_stall());
      check("raw7_stall_const", stall, 1'b1);
      tick();
      wb_en = 1; wb_addr = 7; wb_data = 32'hDEADBEEF;
      settle(); check_all("wb7_same");
      check("wb7_stall_const", stall, !BYPASS);
      tick();
      wb_en = 0;
      settle(); check_all("wb7_next");
      check("wb7_data_const", rs1_data, 32'hDEADBEEF);

      // x0 stays zero and never becomes busy
      rs1_addr = 0; wb_en = 1; wb_addr = 0; wb_data = 32'h1234; iss_en = 1; iss_addr = 0;
      settle(); check_all("x0_same");
      tick();
      wb_en = 0; iss_en = 0;
      settle(); check_all("x0_after");
      check("x0_data_const", rs1_data, 32'd0);
      rs1_used = 0;

      // WAW on x3, then same-cycle write-back and re-issue
      iss_en = 1; iss_addr = 3;
      tick();
      settle(); check("waw3_stall", stall, m_stall());
      check("waw3_stall_const", stall, 1'b1);
      tick();
      iss_en = 0; rs2_addr = 3; rs2_used = 1;
      settle(); check("waw3_busy_kept", stall, m_stall());
      rs2_used = 0; iss_en = 1; wb_en = 1; wb_addr = 3; wb_data = 32'h33;
      settle(); check("waw3_wb_stall", stall, m_stall());
      check("waw3_wb_stall_const", stall, 1'b0);
      tick();
      idle_inputs(); rs2_used = 1;
      settle(); check_all("waw3_after");
      check("waw3_busy_const", stall, 1'b1);
      rs2_used = 0; wb_en = 1; wb_addr = 3; wb_data = 32'h33;
      tick();
      wb_en = 0;

      // Fill and bulk clear
      for (int a = 1; a < NREGS; a++) begin
         wb_en = 1; wb_addr = AW'(a); wb_data = 32'hA5A5A5A5;
         tick();
      end
      wb_en = 0; clr_req = 1;
      tick();
      clr_req = 0;
      busy_cnt = 0; done_cnt = 0;
      for (int c = 0; c < 64; c++) begin
         if (clr_busy) begin
            busy_cnt++;
            rs1_addr = AW'(busy_cnt); rs2_addr = AW'(busy_cnt - 1);
            wb_en = 1; wb_addr = 5; wb_data = 32'hFFFF; iss_en = 1; iss_addr = 9;
            settle();
            check($sformatf("clr_stall_%0d", busy_cnt), stall, 1'b1);
            check($sformatf("clr_pending_%0d", busy_cnt), rs1_data, 32'hA5A5A5A5);
            check($sformatf("clr_cleared_%0d", busy_cnt), rs2_data, 32'd0);
         end else if (clr_done) begin
            done_cnt++;
            wb_en = 0; iss_en = 0;
         end else if (done_cnt > 0) begin
            break;
         end
         @(posedge clk); #1;
      end
      wb_en = 0; iss_en = 0;
      check("clr_cycles", busy_cnt, 31);
      check("clr_done_pulses", done_cnt, 1);
      m_reset();
      for (int a = 0; a < NREGS; a++) begin
         rs1_addr = AW'(a); rs2_addr = AW'(NREGS - 1 - a);
         settle(); check_all($sformatf("post_clr_%0d", a));
      end
      rs1_addr = 9; rs1_used = 1;
      settle(); check("post_clr_iss_ignored", stall, 1'b0);
      rs1_used = 0;

      // Reset in the middle of a clear
      wb_en = 1; wb_addr = 20; wb_data = 32'h77; tick();
      wb_addr = 25; wb_data = 32'h55; tick();
      wb_en = 0; clr_req = 1; tick();
      clr_req = 0;
      repeat (9) begin @(posedge clk); #1; end
      check("midclr_busy_before", clr_busy, 1'b1);
      #1 rst = 1'b1;
      m_reset();
      rs1_addr = 20; rs2_addr = 25;
      settle();
      check("midclr_rst_busy", clr_busy, 1'b0);
      check("midclr_rst_done", clr_done, 1'b0);
      check_all("midclr_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      stray = 0;
      for (int c = 0; c < 40; c++) begin
         if (clr_done || clr_busy) stray++;
         @(posedge clk); #1;
      end
      check("midclr_no_done", stray, 0);
      wb_en = 1; wb_addr = 9; wb_data = 32'h99; tick();
      wb_en = 0; rs1_addr = 9;
      settle(); check_all("midclr_resume");

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         wb_en    = ($urandom_range(0, 2) != 0);
         wb_addr  = AW'($urandom_range(0, NREGS - 1));
         wb_data  = $urandom;
         iss_en   = $urandom_range(0, 1) == 1;
         iss_addr = AW'($urandom_range(0, NREGS - 1));
         rs1_addr = AW'($urandom_range(0, NREGS - 1));
         rs2_addr = AW'($urandom_range(0, NREGS - 1));
         rs1_used = $urandom_range(0, 1) == 1;
         rs2_used = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 3) == 0) rs1_addr = wb_addr;
         if ($urandom_range(0, 3) == 0) iss_addr = wb_addr;
         settle();
         check_all($sformatf("rand_%0d", n));
         tick();
      end
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
